// File: rtl/multi_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel button debouncer.
package multi_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } press_state_e;

    localparam int MIN_DEBOUNCE_CYC = 2;
    localparam int MIN_HOLD_CYC     = 1;
    localparam int MAX_CHANNELS     = 32;

    // One spare bit so the hold counter can park at HOLD_CYC without wrapping.
    function automatic int cnt_width(input int debounce_cyc, input int hold_cyc);
        int m;
        m = (debounce_cyc > hold_cyc) ? debounce_cyc : hold_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: synchroniser, stability filter and press classifier.
module debounce_ch #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic short_press,
    output logic long_press
);
    import multi_debounce_pkg::*;

    localparam int            CW        = cnt_width(DEBOUNCE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    SYNC_IDLE = {2{ACTIVE_LOW}};

    logic [1:0]    sync_q, sync_d;
    logic          s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic [CW-1:0] hold_q, hold_d;
    press_state_e  state_q, state_d;

    assign sync_d = {sync_q[0], btn_in};
    assign s      = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign rise_d = level_d & ~level_q;
    assign fall_d = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= SYNC_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RELEASED;
            hold_q  <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    // A release on the very cycle the hold limit is reached counts as long.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            RELEASED: begin
                if (rise_d) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (fall_d) begin
                    state_d = RELEASED;
                end else begin
                    hold_d = hold_q + CNT_ONE;
                    if (hold_q == HOLD_LAST) begin
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (fall_d) begin
                    state_d = RELEASED;
                end
            end
            default: begin
                state_d = RELEASED;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            PRESSED: begin
                long_d  = (hold_q == HOLD_LAST);
                short_d = fall_d && (hold_q != HOLD_LAST);
            end
            default: begin
                short_d = 1'b0;
                long_d  = 1'b0;
            end
        endcase
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign short_press = short_q;
    assign long_press  = long_q;

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent debounced buttons with edge and short/long press pulses.
module multi_debounce #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 50_000_000,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] short_press,
    output logic [N_CH-1:0] long_press
);
    import multi_debounce_pkg::*;

    if (N_CH < 1 || N_CH > MAX_CHANNELS) begin : g_bad_n_ch
        $error("multi_debounce: N_CH=%0d outside 1..%0d", N_CH, MAX_CHANNELS);
    end
    if (DEBOUNCE_CYC < MIN_DEBOUNCE_CYC) begin : g_bad_debounce
        $error("multi_debounce: DEBOUNCE_CYC=%0d below %0d",
               DEBOUNCE_CYC, MIN_DEBOUNCE_CYC);
    end
    if (HOLD_CYC < MIN_HOLD_CYC) begin : g_bad_hold
        $error("multi_debounce: HOLD_CYC=%0d below %0d", HOLD_CYC, MIN_HOLD_CYC);
    end
    if (ACTIVE_LOW < 0 || ACTIVE_LOW > 1) begin : g_bad_polarity
        $error("multi_debounce: ACTIVE_LOW=%0d must be 0 or 1", ACTIVE_LOW);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW != 0)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_in      (btn_in[i]),
            .level       (level[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .short_press (short_press[i]),
            .long_press  (long_press[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench: directed scenarios plus random bouncing against a timestamp-based model.
module tb_multi_debounce;
    localparam int D = 8;
    localparam int H = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a;
    logic [0:0] btn_b;
    logic [1:0] lvl_a, rise_a, fall_a, short_a, long_a;
    logic [0:0] lvl_b, rise_b, fall_b, short_b, long_b;

    always #5 clk = ~clk;

    multi_debounce #(
        .N_CH(2), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .level(lvl_a), .rise(rise_a), .fall(fall_a),
        .short_press(short_a), .long_press(long_a)
    );

    multi_debounce #(
        .N_CH(1), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .level(lvl_b), .rise(rise_b), .fall(fall_b),
        .short_press(short_b), .long_press(long_b)
    );

    // Channels 0,1 are dut_a; channel 2 is the active-low dut_b.
    logic [2:0] a_lvl, a_rise, a_fall, a_short, a_long;
    assign a_lvl   = {lvl_b, lvl_a};
    assign a_rise  = {rise_b, rise_a};
    assign a_fall  = {fall_b, fall_a};
    assign a_short = {short_b, short_a};
    assign a_long  = {long_b, long_a};

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    bit   p1[3], p2[3], lvl[3], prs[3];
    int   rise_t[3];
    bit   hist[3][$];
    logic [2:0] e_lvl = '0, e_rise = '0, e_fall = '0, e_short = '0, e_long = '0;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pin_val(input int c);
        if (c < 2) return btn_a[c];
        return ~btn_b[0];
    endfunction

    // Level flips once the last D sampled values all disagree with it.
    function automatic bit settled_other(input int c);
        int n;
        n = hist[c].size();
        if (n < D) return 1'b0;
        for (int i = 0; i < D; i++) begin
            if (hist[c][n-1-i] == lvl[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit s;
        cyc++;
        for (int c = 0; c < 3; c++) begin
            e_rise[c]  = 1'b0;
            e_fall[c]  = 1'b0;
            e_short[c] = 1'b0;
            e_long[c]  = 1'b0;
            if (!rst) begin
                p1[c]  = 1'b0;
                p2[c]  = 1'b0;
                lvl[c] = 1'b0;
                prs[c] = 1'b0;
                hist[c].delete();
            end else begin
                s     = p2[c];
                p2[c] = p1[c];
                p1[c] = pin_val(c);
                hist[c].push_back(s);
                if (hist[c].size() > D) void'(hist[c].pop_front());
                if (prs[c] && (cyc - rise_t[c] == H)) e_long[c] = 1'b1;
                if (settled_other(c)) begin
                    lvl[c] = ~lvl[c];
                    hist[c].delete();
                    if (lvl[c]) begin
                        e_rise[c] = 1'b1;
                        prs[c]    = 1'b1;
                        rise_t[c] = cyc;
                    end else begin
                        e_fall[c]  = 1'b1;
                        e_short[c] = prs[c] && (cyc - rise_t[c] < H);
                        prs[c]     = 1'b0;
                    end
                end
            end
            e_lvl[c] = lvl[c];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("level", a_lvl, e_lvl);
            chk("rise", a_rise, e_rise);
            chk("fall", a_fall, e_fall);
            chk("short_press", a_short, e_short);
            chk("long_press", a_long, e_long);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rem[3];
    bit val[3];

    initial begin
        rst   = 1'b0;
        btn_a = 2'b00;
        btn_b = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("reset_level", a_lvl, 3'b000);
        chk("reset_pulses", a_rise | a_fall | a_short | a_long, 3'b000);
        rst = 1'b1;
        step(5);

        // Short press: rise at +10, release after 20, fall/short at +10.
        btn_a[0] = 1'b1;
        step(9);
        chk("r030_level_early", a_lvl, 3'b000);
        step(1);
        chk("r030_level", a_lvl, 3'b001);
        chk("r030_rise", a_rise, 3'b001);
        chk("r030_model_rise", e_rise, 3'b001);
        step(10);
        btn_a[0] = 1'b0;
        step(10);
        chk("r030_fall", a_fall, 3'b001);
        chk("r030_short", a_short, 3'b001);
        chk("r030_model_short", e_short, 3'b001);
        chk("r030_level_off", a_lvl, 3'b000);
        step(20);

        // Bounce: 5 high, 3 low, then steady high.
        btn_a[0] = 1'b1;
        step(5);
        btn_a[0] = 1'b0;
        step(3);
        btn_a[0] = 1'b1;
        step(9);
        chk("r031_level_early", a_lvl, 3'b000);
        step(1);
        chk("r031_level", a_lvl, 3'b001);
        chk("r031_rise", a_rise, 3'b001);
        btn_a[0] = 1'b0;
        step(30);

        // Long press held 60 cycles.
        btn_a[0] = 1'b1;
        step(10);
        chk("r032_rise", a_rise, 3'b001);
        step(31);
        chk("r032_long_early", a_long, 3'b000);
        step(1);
        chk("r032_long", a_long, 3'b001);
        chk("r032_model_long", e_long, 3'b001);
        step(18);
        btn_a[0] = 1'b0;
        step(10);
        chk("r032_fall", a_fall, 3'b001);
        chk("r032_no_short", a_short, 3'b000);
        step(30);

        // Two channels pressed 3 cycles apart.
        btn_a[0] = 1'b1;
        step(3);
        btn_a[1] = 1'b1;
        step(7);
        chk("r033_rise0", a_rise, 3'b001);
        step(3);
        chk("r033_rise1", a_rise, 3'b010);
        chk("r033_level", a_lvl, 3'b011);
        btn_a = 2'b00;
        step(30);

        // Reset pulse mid-press with button still held.
        btn_a[0] = 1'b1;
        step(15);
        chk("r034_pressed", a_lvl, 3'b001);
        rst = 1'b0;
        step(1);
        chk("r034_rst_level", a_lvl, 3'b000);
        chk("r034_rst_pulses", a_rise | a_fall | a_short | a_long, 3'b000);
        rst = 1'b1;
        step(9);
        chk("r034_level_early", a_lvl, 3'b000);
        step(1);
        chk("r034_rise_again", a_rise, 3'b001);
        btn_a[0] = 1'b0;
        step(30);

        // Active-low instance: idle high, pressed low.
        btn_b[0] = 1'b0;
        step(9);
        chk("r035_level_early", a_lvl, 3'b000);
        step(1);
        chk("r035_level", a_lvl, 3'b100);
        chk("r035_rise", a_rise, 3'b100);
        btn_b[0] = 1'b1;
        step(30);

        // Random bouncing on all channels with occasional resets.
        for (int c = 0; c < 3; c++) begin
            rem[c] = 1;
            val[c] = 1'b0;
        end
        repeat (4000) begin
            for (int c = 0; c < 3; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    val[c] = ~val[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ?
                             int'($urandom_range(20, 70)) :
                             int'($urandom_range(1, 12));
                end
            end
            btn_a    = {val[1], val[0]};
            btn_b[0] = ~val[2];
            rst      = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst   = 1'b1;
        btn_a = 2'b00;
        btn_b = 1'b1;
        step(40);
        chk("final_idle", a_lvl, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYC, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
REQ-003 Parameter HOLD_CYC, default 50_000_000: cycles a debounced press must persist before it is classed as a long press (1 s at 50 MHz); minimum 1.
REQ-004 Parameter ACTIVE_LOW, default 0: 1 means a pressed pin reads 0.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 btn_in  input  N_CH  raw asynchronous button pins.
REQ-008 level  output  N_CH  debounced pressed state, 1 = pressed.
REQ-009 rise  output  N_CH  one-cycle pulse on a debounced press.
REQ-010 fall  output  N_CH  one-cycle pulse on a debounced release.
REQ-011 short_press  output  N_CH  one-cycle pulse on release of a press shorter than HOLD_CYC.
REQ-012 long_press  output  N_CH  one-cycle pulse when a press reaches HOLD_CYC.

Function
REQ-013 Each channel passes btn_in through a 2-flop synchroniser, then inverts the result when ACTIVE_LOW=1, producing the sampled value s.
REQ-014 The per-channel stability counter increments each cycle s differs from level and clears to 0 each cycle s equals level.
REQ-015 On the DEBOUNCE_CYC-th consecutive mismatch cycle, level takes s and the counter clears; pin-to-level latency is exactly DEBOUNCE_CYC+2 cycles.
REQ-016 A mismatch shorter than DEBOUNCE_CYC cycles produces no change on any output.
REQ-017 rise and fall are asserted for exactly one cycle, in the same cycle that level changes to 1 or to 0.
REQ-018 Per-channel FSM states: RELEASED, PRESSED, HELD.
REQ-019 RELEASED->PRESSED on rise, with the hold counter cleared.
REQ-020 In PRESSED, the hold counter increments each cycle; on its HOLD_CYC-th cycle the FSM moves to HELD and long_press pulses for one cycle.
REQ-021 PRESSED->RELEASED on fall with short_press pulsing in the fall cycle; HELD->RELEASED on fall with no short_press.
REQ-022 HELD emits no further long_press; the hold counter stops (no wrap).
REQ-023 Counter widths are $clog2 of the maximum of DEBOUNCE_CYC and HOLD_CYC, plus 1; no counter overflows for any legal parameter.
REQ-024 Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-025 A parameter outside its legal range triggers an elaboration-time error.

Reset
REQ-026 When rst=0 at a clock edge: synchroniser flops load the inactive pin value, all counters clear to 0, all outputs clear to 0, and every FSM goes to RELEASED.
REQ-027 Reset asserted mid-press forces outputs low on the next edge with no fall or short_press pulse; a button still held at deassertion is detected as a new press DEBOUNCE_CYC+2 cycles later.

Structure
REQ-028 Package multi_debounce_pkg holds the FSM state enum (RELEASED, PRESSED, HELD) and a counter-width function.
REQ-029 One sub-module, debounce_ch, implements a single channel (synchroniser, filter, FSM); the top level instantiates N_CH copies with a generate loop.

Verification
Benches use DEBOUNCE_CYC=8, HOLD_CYC=32 and N_CH=2 unless stated otherwise.
REQ-030 btn_in[0] 0->1, held for 20 cycles, then 0 -> level[0] rises and rise[0] pulses 10 cycles after the press; fall[0] and short_press[0] pulse 10 cycles after the release.
REQ-031 btn_in[0] high 5 cycles, low 3 cycles, then high steady -> no output during the bounce; level[0] rises 10 cycles after the final rising edge.
REQ-032 btn_in[0] held 60 cycles -> long_press[0] pulses 32 cycles after rise[0]; on release fall[0] pulses with no short_press[0].
REQ-033 btn_in[0] and btn_in[1] pressed 3 cycles apart -> rise[0] and rise[1] each occur 10 cycles after their own press, 3 cycles apart.
REQ-034 rst=0 for 1 cycle while channel 0 is in PRESSED with the button held -> all outputs 0 on the next edge; rise[0] again 10 cycles after rst returns to 1.
REQ-035 ACTIVE_LOW=1 instance, pin idle at 1 and driven to 0 -> level[0]=1 after 10 cycles.
